// File: rtl/random_move_picker_if.sv
// Handshake and board-memory signals between a move requester and random_move_picker.
interface random_move_picker_if;
  logic [3:0] rnd;
  logic       req;
  logic [6:0] occ_addr;
  logic       occ_data;
  logic       busy;
  logic       valid;
  logic       fail;
  logic [3:0] row;
  logic [3:0] col;

  modport master (
    output rnd, req, occ_data,
    input  occ_addr, busy, valid, fail, row, col
  );

  modport slave (
    input  rnd, req, occ_data,
    output occ_addr, busy, valid, fail, row, col
  );
endinterface

// File: rtl/random_move_picker.sv
// Picks a random free board cell: rejection-samples row/col from an LFSR nibble,
// then probes board memory and retries occupied cells up to MAX_TRIES times.
module random_move_picker #(
  parameter int unsigned BOARD_SIZE = 9,
  parameter int unsigned MAX_TRIES  = 64
) (
  input logic                  CLK,
  input logic                  RST,
  random_move_picker_if.slave  mp
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ROW,
    GET_COL,
    LOOKUP,
    CHECK
  } state_t;

  localparam logic [4:0] BS5 = 5'(BOARD_SIZE);
  localparam logic [6:0] BS7 = 7'(BOARD_SIZE);
  localparam logic [7:0] MT8 = 8'(MAX_TRIES);

  state_t     state;
  logic [3:0] row_r;
  logic [3:0] col_r;
  logic [7:0] tries;
  logic [7:0] tries_inc;
  logic       rnd_ok;

  assign tries_inc = tries + 8'd1;
  assign rnd_ok    = ({1'b0, mp.rnd} < BS5);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      row_r       <= '0;
      col_r       <= '0;
      tries       <= '0;
      mp.row      <= '0;
      mp.col      <= '0;
      mp.occ_addr <= '0;
      mp.busy     <= 1'b0;
      mp.valid    <= 1'b0;
      mp.fail     <= 1'b0;
    end else begin
      mp.valid <= 1'b0;
      mp.fail  <= 1'b0;
      case (state)
        IDLE: begin
          if (mp.req) begin
            state   <= GET_ROW;
            tries   <= '0;
            mp.busy <= 1'b1;
          end
        end
        GET_ROW: begin
          if (rnd_ok) begin
            row_r <= mp.rnd;
            state <= GET_COL;
          end
        end
        GET_COL: begin
          // Address is formed here so it is already registered on LOOKUP entry.
          if (rnd_ok) begin
            col_r       <= mp.rnd;
            mp.occ_addr <= 7'(row_r) * BS7 + 7'(mp.rnd);
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          state <= CHECK;
        end
        CHECK: begin
          mp.occ_addr <= '0;
          if (!mp.occ_data) begin
            mp.row   <= row_r;
            mp.col   <= col_r;
            mp.valid <= 1'b1;
            mp.busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            tries <= tries_inc;
            if (tries_inc == MT8) begin
              mp.fail <= 1'b1;
              mp.busy <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= GET_ROW;
            end
          end
        end
        default: begin
          state       <= IDLE;
          mp.busy     <= 1'b0;
          mp.occ_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_move_picker.sv
// Directed bench for random_move_picker (BOARD_SIZE=9, MAX_TRIES=4).
module tb_random_move_picker;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  random_move_picker_if mif ();

  random_move_picker #(.BOARD_SIZE(9), .MAX_TRIES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .mp  (mif)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic [3:0] rnd;
    logic       occ;
    logic       busy;
    logic       valid;
    logic       fail;
    logic [3:0] row;
    logic [3:0] col;
    logic [6:0] addr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic req, input logic [3:0] rnd, input logic occ,
                     input logic busy, input logic valid, input logic fail,
                     input logic [3:0] row, input logic [3:0] col, input logic [6:0] addr);
    vec_t v;
    v = '{rst, req, rnd, occ, busy, valid, fail, row, col, addr};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int busy, input int valid, input int fail,
                          input int row, input int col);
    chk({tag, " busy"},  int'(mif.busy),  busy);
    chk({tag, " valid"}, int'(mif.valid), valid);
    chk({tag, " fail"},  int'(mif.fail),  fail);
    chk({tag, " row"},   int'(mif.row),   row);
    chk({tag, " col"},   int'(mif.col),   col);
  endtask

  initial begin
    int exp_row;
    int exp_col;
    int vcount;

    mif.req = 1'b0;
    mif.rnd = '0;
    mif.occ_data = 1'b0;

    //   rst req rnd occ | busy val fail row col addr
    add(1, 0,  0, 0,   0, 0, 0, 0, 0,  0);   // reset state
    add(0, 1,  0, 0,   1, 0, 0, 0, 0,  0);   // best case 3,5
    add(0, 0,  3, 0,   1, 0, 0, 0, 0,  0);
    add(0, 0,  5, 0,   1, 0, 0, 0, 0, 32);
    add(0, 0,  0, 0,   1, 0, 0, 0, 0, 32);
    add(0, 0,  0, 0,   0, 1, 0, 3, 5,  0);
    add(0, 0,  0, 0,   0, 0, 0, 3, 5,  0);
    add(0, 1,  0, 0,   1, 0, 0, 3, 5,  0);   // rejections 12,15,2,9,7
    add(0, 0, 12, 0,   1, 0, 0, 3, 5,  0);
    add(0, 0, 15, 0,   1, 0, 0, 3, 5,  0);
    add(0, 0,  2, 0,   1, 0, 0, 3, 5,  0);
    add(0, 0,  9, 0,   1, 0, 0, 3, 5,  0);
    add(0, 0,  7, 0,   1, 0, 0, 3, 5, 25);
    add(0, 0,  0, 0,   1, 0, 0, 3, 5, 25);
    add(0, 0,  0, 0,   0, 1, 0, 2, 7,  0);
    add(0, 1,  0, 0,   1, 0, 0, 2, 7,  0);   // occupied retry then free
    add(0, 0,  1, 0,   1, 0, 0, 2, 7,  0);
    add(0, 0,  1, 0,   1, 0, 0, 2, 7, 10);
    add(0, 0,  0, 0,   1, 0, 0, 2, 7, 10);
    add(0, 0,  0, 1,   1, 0, 0, 2, 7,  0);
    add(0, 0,  4, 0,   1, 0, 0, 2, 7,  0);
    add(0, 0,  0, 0,   1, 0, 0, 2, 7, 36);
    add(0, 0,  0, 0,   1, 0, 0, 2, 7, 36);
    add(0, 0,  0, 0,   0, 1, 0, 4, 0,  0);
    add(0, 1,  0, 0,   1, 0, 0, 4, 0,  0);   // reset in LOOKUP
    add(0, 0,  6, 0,   1, 0, 0, 4, 0,  0);
    add(0, 0,  8, 0,   1, 0, 0, 4, 0, 62);
    add(1, 0,  0, 0,   0, 0, 0, 0, 0,  0);
    add(0, 0,  0, 0,   0, 0, 0, 0, 0,  0);
    add(0, 0,  0, 0,   0, 0, 0, 0, 0,  0);
    add(0, 1,  0, 0,   1, 0, 0, 0, 0,  0);   // reset beats CHECK completion
    add(0, 0,  1, 0,   1, 0, 0, 0, 0,  0);
    add(0, 0,  2, 0,   1, 0, 0, 0, 0, 11);
    add(0, 0,  0, 0,   1, 0, 0, 0, 0, 11);
    add(1, 0,  0, 0,   0, 0, 0, 0, 0,  0);
    add(0, 0,  0, 0,   0, 0, 0, 0, 0,  0);
    add(1, 1,  0, 0,   0, 0, 0, 0, 0,  0);   // reset beats req
    add(0, 0,  0, 0,   0, 0, 0, 0, 0,  0);

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      RST          = vq[i].rst;
      mif.req      = vq[i].req;
      mif.rnd      = vq[i].rnd;
      mif.occ_data = vq[i].occ;
      tick();
      chk_outs(tag, int'(vq[i].busy), int'(vq[i].valid), int'(vq[i].fail),
               int'(vq[i].row), int'(vq[i].col));
      chk({tag, " occ_addr"}, int'(mif.occ_addr), int'(vq[i].addr));
    end

    // Back-to-back: req high whenever IDLE, toggling while busy; one move per 5 edges.
    RST = 1'b0;
    mif.occ_data = 1'b0;
    exp_row = 0;
    exp_col = 0;
    vcount  = 0;
    for (int k = 0; k < 15; k++) begin
      mif.req = (k % 5 == 0) ? 1'b1 : 1'(k % 2);
      mif.rnd = 4'(1 + k / 5);
      tick();
      if (k % 5 == 4) begin
        exp_row = 1 + k / 5;
        exp_col = 1 + k / 5;
      end
      if (mif.valid) vcount++;
      chk_outs($sformatf("b2b%0d", k), (k % 5 == 4) ? 0 : 1, (k % 5 == 4) ? 1 : 0, 0,
               exp_row, exp_col);
    end
    chk("b2b move count", vcount, 3);

    // Four occupied probes exhaust MAX_TRIES; row/col keep the last accepted move.
    mif.req = 1'b1;
    mif.rnd = '0;
    tick();
    chk_outs("fail start", 1, 0, 0, 3, 3);
    mif.req = 1'b0;
    for (int t = 0; t < 4; t++) begin
      mif.occ_data = 1'b0;
      mif.rnd = 4'(t + 1);
      tick();
      mif.rnd = 4'(t);
      tick();
      chk($sformatf("fail try%0d occ_addr", t), int'(mif.occ_addr), (t + 1) * 9 + t);
      mif.rnd = '0;
      tick();
      mif.occ_data = 1'b1;
      tick();
      chk_outs($sformatf("fail try%0d", t), (t == 3) ? 0 : 1, 0, (t == 3) ? 1 : 0, 3, 3);
    end
    mif.occ_data = 1'b0;
    tick();
    chk_outs("fail after", 0, 0, 0, 3, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
